// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for a 5-stage pipeline.
// Drives PC, IF/ID, ID/EX and EX/MEM hold/flush controls from load-use hazards,
// taken branches resolved in EX, and multi-cycle data-memory waits (with timeout).
// Ports:
//   i_clk, i_rst (async, active-low)
//   i_id_rs1/i_id_rs2/i_id_use_rs1/i_id_use_rs2 : source operands of the ID instruction
//   i_ex_rd/i_ex_mem_read                       : destination and load flag of the EX instruction
//   i_ex_br_taken                               : taken branch/jump redirect from EX
//   i_mem_req/i_mem_ready                       : data-memory handshake of the MEM stage
//   o_pc_hold, o_if_id_hold, o_if_id_flush, o_id_ex_hold, o_id_ex_flush, o_ex_mem_hold
//   o_mem_tmo_err                               : 1-cycle pulse after a memory-wait timeout
//   o_stall_cnt/o_flush_cnt                     : saturating performance counters
module pipe_hazard_ctrl #(
    parameter int unsigned REG_AW      = 6,
    parameter int unsigned TMO_W       = 8,
    parameter int unsigned MEM_TIMEOUT = 200,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_mem_read,
    input  logic              i_ex_br_taken,
    input  logic              i_mem_req,
    input  logic              i_mem_ready,
    output logic              o_pc_hold,
    output logic              o_if_id_hold,
    output logic              o_if_id_flush,
    output logic              o_id_ex_hold,
    output logic              o_id_ex_flush,
    output logic              o_ex_mem_hold,
    output logic              o_mem_tmo_err,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    typedef enum logic [0:0] {StRun, StMemWait} state_e;

    localparam logic [TMO_W-1:0] TmoLimit = TMO_W'(MEM_TIMEOUT);

    state_e             r_state, w_state_nxt;
    logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
    logic               r_tmo_err, w_tmo_err_nxt;
    logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;

    logic w_memwait, w_loaduse;
    logic w_pc_hold, w_if_id_hold, w_if_id_flush, w_id_ex_hold, w_id_ex_flush, w_ex_mem_hold;

    // A request that completes in its own cycle never stalls.
    assign w_memwait = !i_mem_ready && ((r_state == StMemWait) || i_mem_req);

    // x0 is hardwired zero, so a load targeting it creates no dependency.
    assign w_loaduse = i_ex_mem_read && (i_ex_rd != '0) &&
                       ((i_id_use_rs1 && (i_id_rs1 == i_ex_rd)) ||
                        (i_id_use_rs2 && (i_id_rs2 == i_ex_rd)));

    always_comb begin
        w_state_nxt   = r_state;
        w_tmo_nxt     = r_tmo;
        w_tmo_err_nxt = 1'b0;
        unique case (r_state)
            StRun: begin
                if (i_mem_req && !i_mem_ready) begin
                    w_state_nxt = StMemWait;
                    w_tmo_nxt   = TMO_W'(1);
                end
            end
            StMemWait: begin
                if (i_mem_ready) begin
                    w_state_nxt = StRun;
                    w_tmo_nxt   = '0;
                end else if (r_tmo == TmoLimit) begin
                    w_state_nxt   = StRun;
                    w_tmo_nxt     = '0;
                    w_tmo_err_nxt = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            default: begin
                w_state_nxt = StRun;
                w_tmo_nxt   = '0;
            end
        endcase
    end

    // Priority: memory wait freezes everything (a taken branch waits in EX),
    // then branch redirect, then load-use bubble.
    always_comb begin
        w_pc_hold     = 1'b0;
        w_if_id_hold  = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_hold  = 1'b0;
        w_id_ex_flush = 1'b0;
        w_ex_mem_hold = 1'b0;
        if (w_memwait) begin
            w_pc_hold     = 1'b1;
            w_if_id_hold  = 1'b1;
            w_id_ex_hold  = 1'b1;
            w_ex_mem_hold = 1'b1;
        end else if (i_ex_br_taken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_loaduse) begin
            w_pc_hold     = 1'b1;
            w_if_id_hold  = 1'b1;
            w_id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= StRun;
            r_tmo       <= '0;
            r_tmo_err   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tmo     <= w_tmo_nxt;
            r_tmo_err <= w_tmo_err_nxt;
            if (w_pc_hold && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_id_ex_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    // Reset forces the combinational controls low without waiting for a clock.
    assign o_pc_hold     = w_pc_hold     & i_rst;
    assign o_if_id_hold  = w_if_id_hold  & i_rst;
    assign o_if_id_flush = w_if_id_flush & i_rst;
    assign o_id_ex_hold  = w_id_ex_hold  & i_rst;
    assign o_id_ex_flush = w_id_ex_flush & i_rst;
    assign o_ex_mem_hold = w_ex_mem_hold & i_rst;
    assign o_mem_tmo_err = r_tmo_err;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;

endmodule
